time_counter: RTL and testbench
===============================

TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchroniser flops on sec_clk (legal range 2-4).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sec_clk  input  1  slow square wave from the clock divider; each level change (rising or falling) marks one elapsed second; asynchronous to clk.
REQ-005 run  input  1  1 = time advances on ticks; 0 = time held.
REQ-006 set_en  input  1  one-cycle request to load set_hours/set_mins.
REQ-007 set_hours  input  8  BCD hours, {tens[7:4], units[3:0]}.
REQ-008 set_mins  input  8  BCD minutes, same packing.
REQ-009 hours_bcd  output  8  current hours, BCD 00-23.
REQ-010 mins_bcd  output  8  current minutes, BCD 00-59.
REQ-011 secs_bcd  output  8  current seconds, BCD 00-59.
REQ-012 tick  output  1  one-cycle pulse per detected sec_clk transition.
REQ-013 day_tick  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
REQ-014 set_ack  output  1  one-cycle pulse: set accepted.
REQ-015 set_err  output  1  one-cycle pulse: set rejected.

Function
REQ-016 sec_clk SHALL pass through SYNC_STAGES flops, plus one history flop, all reset to 0.
REQ-017 Edge detect SHALL be the XOR of the last sync stage and the history flop; both edges count.
REQ-018 tick SHALL be registered and SHALL be high for exactly one clk cycle, SYNC_STAGES+1 rising clk edges after the first clk edge that samples the new sec_clk level.
REQ-019 A guard counter SHALL suppress edge detection for the first SYNC_STAGES+1 clk cycles after reset release, so that a sec_clk level held through reset produces no tick.
REQ-020 Time update SHALL occur on the same clk edge that raises tick, when run=1 and no set is accepted that cycle.
REQ-021 Seconds SHALL count units 0-9, then tens 0-5, and wrap from 59 to 00 with a carry into minutes.
REQ-022 Minutes SHALL count the same way, wrapping from 59 to 00 with a carry into hours.
REQ-023 Hours SHALL wrap 23 -> 00; 09 -> 10 and 19 -> 20 SHALL be handled as BCD.
REQ-024 day_tick SHALL pulse on the same edge that time transitions 23:59:59 -> 00:00:00.
REQ-025 run=0: tick still pulses; hours, minutes and seconds hold.
REQ-026 set_en valid condition: both nibbles <= 9; set_hours <= 0x23; set_mins <= 0x59.
REQ-027 Valid set: on the edge sampling set_en, load hours and minutes, force secs to 00, and pulse set_ack high for one cycle (registered).
REQ-028 Invalid set: time unchanged; set_err pulses for one cycle; set_ack stays 0.
REQ-029 A set and a tick in the same cycle: the set has priority; that tick pulses on the output but does not advance time; day_tick does not fire.
REQ-030 set_en held for N cycles SHALL be treated as N independent requests.
REQ-031 Outputs SHALL never hold non-BCD or out-of-range values.

Reset
REQ-032 When rst is asserted, all registers SHALL clear immediately: time 00:00:00, tick/day_tick/set_ack/set_err = 0, sync/history = 0, guard counter restarted.
REQ-033 Reset asserted mid-operation SHALL discard any in-flight edge or set request; no pulse SHALL emit on release.

Verification
REQ-034 Release reset with sec_clk=1 and run=1 -> no tick within 10 cycles; time 00:00:00.
REQ-035 Toggle sec_clk 0->1->0 with 20 cycles between toggles (run=1) -> two ticks, each 1 cycle wide, 3 edges after sampling (SYNC_STAGES=2); secs_bcd 0x02.
REQ-036 Set 0x23/0x59, then 60 sec_clk toggles -> day_tick once at the 60th tick; time 00:00:00; mins_bcd 0x00, hours_bcd 0x00.
REQ-037 set_en with set_hours=0x24, then with set_mins=0x5A -> set_err pulses twice, no set_ack, time unchanged.
REQ-038 set_en 0x12/0x34 in the same cycle as a tick -> time 12:34:00; set_ack=1; tick=1; secs stays 00.
REQ-039 run=0 for 5 toggles -> 5 ticks, time constant; then assert rst mid-count -> immediate 00:00:00.

Source files
------------

// File: rtl/time_counter.sv
// time_counter: 24-hour BCD time-of-day counter driven by a slow sec_clk.
//   clk, rst        system clock, asynchronous active-high reset
//   sec_clk         asynchronous square wave; every level change is one second
//   run             1 = time advances on ticks, 0 = time held
//   set_en          one-cycle request to load set_hours/set_mins (BCD)
//   hours_bcd/mins_bcd/secs_bcd  current time, BCD
//   tick            one-cycle pulse per detected sec_clk transition
//   day_tick        one-cycle pulse on 23:59:59 -> 00:00:00
//   set_ack/set_err one-cycle pulse: set accepted / rejected
module time_counter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_clk,
  input  logic       run,
  input  logic       set_en,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_mins,
  output logic [7:0] hours_bcd,
  output logic [7:0] mins_bcd,
  output logic [7:0] secs_bcd,
  output logic       tick,
  output logic       day_tick,
  output logic       set_ack,
  output logic       set_err
);

  localparam int unsigned GUARD_MAX = SYNC_STAGES + 1;
  localparam int unsigned GW        = $clog2(GUARD_MAX + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_MAX);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [GW-1:0]          guard_q, guard_d;
  logic                   edge_q, edge_d;
  logic                   tick_q, tick_d;
  logic                   day_tick_q, day_tick_d;
  logic                   set_ack_q, set_ack_d;
  logic                   set_err_q, set_err_d;
  logic [7:0]             hours_q, hours_d;
  logic [7:0]             mins_q, mins_d;
  logic [7:0]             secs_q, secs_d;

  logic       guard_done;
  logic       set_ok;
  logic       advance;
  logic [8:0] secs_inc;
  logic [8:0] mins_inc;
  logic [8:0] hours_inc;

  // Returns {carry, next} for a BCD 00-59 field.
  function automatic logic [8:0] inc60(input logic [7:0] v);
    logic [8:0] r;
    if (v[3:0] != 4'd9)      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5) r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     r = {1'b1, 8'h00};
    return r;
  endfunction

  // Returns {carry, next} for a BCD 00-23 field.
  function automatic logic [8:0] inc24(input logic [7:0] v);
    logic [8:0] r;
    if (v == 8'h23)          r = {1'b1, 8'h00};
    else if (v[3:0] != 4'd9) r = {1'b0, v[7:4], v[3:0] + 4'd1};
    else                     r = {1'b0, v[7:4] + 4'd1, 4'd0};
    return r;
  endfunction

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], sec_clk};
    hist_d     = sync_q[SYNC_STAGES-1];
    guard_done = (guard_q == GUARD_LAST);
    guard_d    = guard_done ? guard_q : guard_q + 1'b1;

    // The guard hides the synchroniser filling up with a level that was
    // already present during reset; the extra edge register gives the
    // SYNC_STAGES+1 edge latency from first sample to tick.
    edge_d = guard_done & (sync_q[SYNC_STAGES-1] ^ hist_q);
    tick_d = edge_q;

    set_ok = (set_hours[7:4] <= 4'd9) && (set_hours[3:0] <= 4'd9) &&
             (set_hours <= 8'h23) &&
             (set_mins[7:4] <= 4'd9) && (set_mins[3:0] <= 4'd9) &&
             (set_mins <= 8'h59);
    set_ack_d = set_en & set_ok;
    set_err_d = set_en & ~set_ok;

    // An accepted set wins over a coinciding tick.
    advance = edge_q & run & ~set_ack_d;

    secs_inc  = inc60(secs_q);
    mins_inc  = inc60(mins_q);
    hours_inc = inc24(hours_q);

    hours_d    = hours_q;
    mins_d     = mins_q;
    secs_d     = secs_q;
    day_tick_d = 1'b0;

    if (set_ack_d) begin
      hours_d = set_hours;
      mins_d  = set_mins;
      secs_d  = 8'h00;
    end else if (advance) begin
      secs_d = secs_inc[7:0];
      if (secs_inc[8]) begin
        mins_d = mins_inc[7:0];
        if (mins_inc[8]) begin
          hours_d    = hours_inc[7:0];
          day_tick_d = hours_inc[8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      hist_q     <= 1'b0;
      guard_q    <= '0;
      edge_q     <= 1'b0;
      tick_q     <= 1'b0;
      day_tick_q <= 1'b0;
      set_ack_q  <= 1'b0;
      set_err_q  <= 1'b0;
      hours_q    <= '0;
      mins_q     <= '0;
      secs_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      guard_q    <= guard_d;
      edge_q     <= edge_d;
      tick_q     <= tick_d;
      day_tick_q <= day_tick_d;
      set_ack_q  <= set_ack_d;
      set_err_q  <= set_err_d;
      hours_q    <= hours_d;
      mins_q     <= mins_d;
      secs_q     <= secs_d;
    end
  end

  assign hours_bcd = hours_q;
  assign mins_bcd  = mins_q;
  assign secs_bcd  = secs_q;
  assign tick      = tick_q;
  assign day_tick  = day_tick_q;
  assign set_ack   = set_ack_q;
  assign set_err   = set_err_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter (SYNC_STAGES = 2).
module tb_time_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_clk = 1'b1;
  logic       run = 1'b1;
  logic       set_en = 1'b0;
  logic [7:0] set_hours = '0;
  logic [7:0] set_mins = '0;
  logic [7:0] hours_bcd, mins_bcd, secs_bcd;
  logic       tick, day_tick, set_ack, set_err;

  int tests_run = 0;
  int tests_failed = 0;
  int ticks_seen = 0;
  int days_seen = 0;

  time_counter #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sec_clk(sec_clk), .run(run),
    .set_en(set_en), .set_hours(set_hours), .set_mins(set_mins),
    .hours_bcd(hours_bcd), .mins_bcd(mins_bcd), .secs_bcd(secs_bcd),
    .tick(tick), .day_tick(day_tick), .set_ack(set_ack), .set_err(set_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [23:0] exp);
    check(tag, {hours_bcd, mins_bcd, secs_bcd}, {8'h00, exp});
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (tick) ticks_seen++;
      if (day_tick) days_seen++;
    end
  endtask

  task automatic toggle_sec();
    @(negedge clk);
    sec_clk = ~sec_clk;
    run_cycles(20);
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m);
    @(negedge clk);
    set_hours = h;
    set_mins  = m;
    set_en    = 1'b1;
    @(posedge clk); #1;
    set_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with sec_clk high through reset.
    repeat (3) @(posedge clk);
    #1;
    check_time("reset_time", 24'h000000);
    check("reset_pulses", {tick, day_tick, set_ack, set_err}, 0);
    @(negedge clk) rst = 1'b0;
    ticks_seen = 0;
    run_cycles(10);
    check("no_tick_after_release", ticks_seen, 0);
    check_time("time_after_release", 24'h000000);

    // Restart with sec_clk low, then exact tick latency.
    @(negedge clk) begin rst = 1'b1; sec_clk = 1'b0; end
    @(negedge clk) rst = 1'b0;
    run_cycles(6);
    @(negedge clk) sec_clk = 1'b1;
    @(posedge clk); #1; check("lat_e0", tick, 0);
    @(posedge clk); #1; check("lat_e1", tick, 0);
    @(posedge clk); #1; check("lat_e2", tick, 0);
    @(posedge clk); #1; check("lat_e3", tick, 1);
    check("secs_after_tick1", secs_bcd, 8'h01);
    @(posedge clk); #1; check("lat_e4", tick, 0);
    run_cycles(15);
    ticks_seen = 0;
    toggle_sec();
    check("falling_edge_tick", ticks_seen, 1);
    check("secs_two", secs_bcd, 8'h02);

    // Day rollover.
    do_set(8'h23, 8'h59);
    check("set_ack_2359", set_ack, 1);
    check_time("set_2359", 24'h235900);
    ticks_seen = 0; days_seen = 0;
    repeat (59) toggle_sec();
    check("no_day_before_60", days_seen, 0);
    check_time("at_235959", 24'h235959);
    toggle_sec();
    check("day_tick_once", days_seen, 1);
    check("ticks_60", ticks_seen, 60);
    check_time("rollover_000000", 24'h000000);

    // BCD hour carry 09 -> 10.
    do_set(8'h09, 8'h59);
    repeat (60) toggle_sec();
    check_time("hour_09_to_10", 24'h100000);

    // Invalid sets.
    do_set(8'h24, 8'h00);
    check("err_hours24", set_err, 1);
    check("noack_hours24", set_ack, 0);
    do_set(8'h12, 8'h5A);
    check("err_mins5a", set_err, 1);
    check("noack_mins5a", set_ack, 0);
    do_set(8'h1A, 8'h00);
    check("err_hours1a", set_err, 1);
    check_time("time_unchanged", 24'h100000);

    // Set coinciding with a tick: set wins.
    @(negedge clk) sec_clk = ~sec_clk;
    repeat (3) @(posedge clk);
    @(negedge clk) begin set_hours = 8'h12; set_mins = 8'h34; set_en = 1'b1; end
    @(posedge clk); #1;
    set_en = 1'b0;
    check("coinc_tick", tick, 1);
    check("coinc_ack", set_ack, 1);
    check("coinc_no_day", day_tick, 0);
    check_time("coinc_time", 24'h123400);
    run_cycles(10);
    check("coinc_secs_hold", secs_bcd, 8'h00);

    // set_en held two cycles = two requests.
    @(negedge clk) begin set_hours = 8'h05; set_mins = 8'h06; set_en = 1'b1; end
    @(posedge clk); #1; check("held_ack1", set_ack, 1);
    @(posedge clk); #1; check("held_ack2", set_ack, 1);
    set_en = 1'b0;
    @(posedge clk); #1; check("held_ack_end", set_ack, 0);

    // run=0 holds time, ticks continue.
    run = 1'b0;
    ticks_seen = 0;
    repeat (5) toggle_sec();
    check("hold_ticks", ticks_seen, 5);
    check_time("hold_time", 24'h050600);
    run = 1'b1;
    toggle_sec();
    check_time("resume_time", 24'h050601);

    // Asynchronous reset mid-count, with an edge in flight.
    @(negedge clk) sec_clk = ~sec_clk;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_time("async_reset_time", 24'h000000);
    @(negedge clk) rst = 1'b0;
    ticks_seen = 0;
    run_cycles(10);
    check("no_tick_after_midreset", ticks_seen, 0);
    check_time("time_after_midreset", 24'h000000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
